// File: rtl/isa_pkg.sv
// Shared ISA definitions: op kinds, opcode/funct fields and the NOP word.
// The control unit decodes exactly these encodings.
package isa_pkg;

  // Operation kinds as presented on the loader request port; 10..15 are illegal.
  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_MUL  = 4'd4,
    OP_BEQ  = 4'd5,
    OP_BNE  = 4'd6,
    OP_ADDI = 4'd7,
    OP_LW   = 4'd8,
    OP_SW   = 4'd9
  } op_kind_e;

  // Primary opcodes
  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_BEQ   = 6'b000100;
  localparam logic [5:0] OPC_BNE   = 6'b001000;
  localparam logic [5:0] OPC_ADDI  = 6'b001001;
  localparam logic [5:0] OPC_LW    = 6'b100011;
  localparam logic [5:0] OPC_SW    = 6'b101011;

  // R-type function codes
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_MUL = 6'b011000;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

endpackage

// File: rtl/instr_encoder.sv
// Combinational instruction encoder: op kind plus fields -> 32-bit word.
// Unknown op kinds produce a zero word and raise illegal.
module instr_encoder
  import isa_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [15:0] imm,
  output logic [31:0] word,
  output logic        illegal
);

  // Select the R-type or I-type layout from the op kind.
  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (op)
      OP_ADD:  word = {OPC_RTYPE, rs, rt, rd, 5'b00000, FN_ADD};
      OP_SUB:  word = {OPC_RTYPE, rs, rt, rd, 5'b00000, FN_SUB};
      OP_AND:  word = {OPC_RTYPE, rs, rt, rd, 5'b00000, FN_AND};
      OP_OR:   word = {OPC_RTYPE, rs, rt, rd, 5'b00000, FN_OR};
      OP_MUL:  word = {OPC_RTYPE, rs, rt, rd, 5'b00000, FN_MUL};
      OP_BEQ:  word = {OPC_BEQ, rs, rt, imm};
      OP_BNE:  word = {OPC_BNE, rs, rt, imm};
      OP_ADDI: word = {OPC_ADDI, rs, rt, imm};
      // Memory ops: rs is the base register, rt the data register.
      OP_LW:   word = {OPC_LW, rs, rt, imm};
      OP_SW:   word = {OPC_SW, rs, rt, imm};
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Program loader: encodes instruction requests and writes them to
// consecutive instruction-memory words, holding the core until done.
// Optional feature macro: ENC_PAD_EN -- after draining, fill all remaining
// words with NOP before entering DONE.
module instr_encoder_loader
  import isa_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              finish,
  input  logic              reqValid,
  output logic              reqReady,
  input  logic [3:0]        reqOp,
  input  logic [4:0]        reqRs,
  input  logic [4:0]        reqRt,
  input  logic [4:0]        reqRd,
  input  logic [15:0]       reqImm,
  output logic              imemWe,
  output logic [ADDR_W-1:0] imemAddr,
  output logic [31:0]       imemData,
  input  logic              imemReady,
  output logic              cpuHold,
  output logic [ADDR_W:0]   loadCount,
  output logic              busy,
  output logic              done,
  output logic              errIllegal
);

  localparam int CW    = ADDR_W + 1;
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [CW-1:0] LAST_ADDR = CW'(DEPTH - 1);
  localparam logic [CW:0]   DEPTH_W   = (CW + 1)'(DEPTH);

`ifdef ENC_PAD_EN
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_DRAIN = 3'd2,
    S_PAD   = 3'd3,
    S_DONE  = 3'd4
  } state_e;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_DRAIN = 3'd2,
    S_DONE  = 3'd4
  } state_e;
`endif

  state_e        state;
  logic [CW-1:0] addr_cnt;
  logic [CW:0]   inflight;
  logic [31:0]   enc_word;
  logic          enc_illegal;
  logic          fire;
  logic          accept;

  instr_encoder u_enc (
    .op      (reqOp),
    .rs      (reqRs),
    .rt      (reqRt),
    .rd      (reqRd),
    .imm     (reqImm),
    .word    (enc_word),
    .illegal (enc_illegal)
  );

  // Words committed plus the one waiting in the buffer must stay below DEPTH.
  assign inflight = {1'b0, addr_cnt} + {{CW{1'b0}}, imemWe};
  assign fire     = imemWe && imemReady;
  assign reqReady = (state == S_LOAD) && (!imemWe || imemReady) && (inflight < DEPTH_W);
  assign accept   = reqValid && reqReady;

  // The buffered word always targets the next unwritten address.
  assign imemAddr = addr_cnt[ADDR_W-1:0];
  assign done     = (state == S_DONE);
  assign cpuHold  = (state != S_DONE);
`ifdef ENC_PAD_EN
  assign busy = (state == S_LOAD) || (state == S_DRAIN) || (state == S_PAD);
`else
  assign busy = (state == S_LOAD) || (state == S_DRAIN);
`endif

  // Session FSM, one-entry output buffer and write counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      imemWe     <= 1'b0;
      imemData   <= '0;
      addr_cnt   <= '0;
      loadCount  <= '0;
      errIllegal <= 1'b0;
    end else begin
      // A completed write frees the buffer unless refilled below.
      if (fire) begin
        addr_cnt <= addr_cnt + CW'(1);
        imemWe   <= 1'b0;
      end
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state      <= S_LOAD;
            addr_cnt   <= '0;
            loadCount  <= '0;
            errIllegal <= 1'b0;
          end
        end
        S_LOAD: begin
          if (fire) loadCount <= loadCount + CW'(1);
          if (accept) begin
            if (enc_illegal) begin
              errIllegal <= 1'b1;
            end else begin
              imemWe   <= 1'b1;
              imemData <= enc_word;
            end
          end
          // Leaving on the last write keeps done one edge after it completes.
          if (finish || (fire && addr_cnt == LAST_ADDR)) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (fire) loadCount <= loadCount + CW'(1);
          if (!imemWe) begin
`ifdef ENC_PAD_EN
            if (addr_cnt < DEPTH_C) begin
              state    <= S_PAD;
              imemWe   <= 1'b1;
              imemData <= NOP_WORD;
            end else begin
              state <= S_DONE;
            end
`else
            state <= S_DONE;
`endif
          end
        end
`ifdef ENC_PAD_EN
        S_PAD: begin
          // Keep the NOP buffered until the final address has been written.
          if (imemWe) begin
            if (fire && addr_cnt != LAST_ADDR) imemWe <= 1'b1;
          end else begin
            state <= S_DONE;
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench for instr_encoder_loader (ADDR_W = 3, DEPTH = 8).
module tb_instr_encoder_loader;

  localparam int AW    = 3;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n, start, finish, reqValid, reqReady;
  logic [3:0]    reqOp;
  logic [4:0]    reqRs, reqRt, reqRd;
  logic [15:0]   reqImm;
  logic          imemWe, imemReady, cpuHold, busy, done, errIllegal;
  logic [AW-1:0] imemAddr;
  logic [31:0]   imemData;
  logic [AW:0]   loadCount;

  int n_checks = 0;
  int n_pass   = 0;
  int rdy_pct  = 100;

  // Reference model state
  int          m_addr;
  bit          m_err;
  int          base;
  int          exp_addr[$];
  logic [31:0] exp_data[$];
  int          obs_addr[$];
  logic [31:0] obs_data[$];

  instr_encoder_loader #(.ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .finish(finish),
    .reqValid(reqValid), .reqReady(reqReady), .reqOp(reqOp),
    .reqRs(reqRs), .reqRt(reqRt), .reqRd(reqRd), .reqImm(reqImm),
    .imemWe(imemWe), .imemAddr(imemAddr), .imemData(imemData),
    .imemReady(imemReady), .cpuHold(cpuHold), .loadCount(loadCount),
    .busy(busy), .done(done), .errIllegal(errIllegal)
  );

  always #5 clk = ~clk;

  // Memory-side ready, randomised by percentage.
  always begin
    @(posedge clk);
    #1;
    imemReady = (rdy_pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < rdy_pct);
  end

  // Record every completed memory write.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && imemWe === 1'b1 && imemReady === 1'b1) begin
      obs_addr.push_back(int'(imemAddr));
      obs_data.push_back(imemData);
    end
  end

  // Encoding derived from the field layout: {illegal, word}.
  function automatic logic [32:0] ref_enc(int op, int rs, int rt, int rd, int imm);
    int fn[5];
    int oc[5];
    longint unsigned w;
    fn = '{32, 34, 36, 37, 24};
    oc = '{4, 8, 9, 35, 43};
    if (op < 5) begin
      w = longint'(rs) * 2097152 + longint'(rt) * 65536 + longint'(rd) * 2048 + longint'(fn[op]);
      return {1'b0, w[31:0]};
    end else if (op < 10) begin
      w = longint'(oc[op-5]) * 67108864 + longint'(rs) * 2097152 + longint'(rt) * 65536 + longint'(imm);
      return {1'b0, w[31:0]};
    end
    return {1'b1, 32'h0};
  endfunction

  task automatic send(input int op, input int rs, input int rt, input int rd, input int imm,
                      input int budget, output bit acc);
    logic [32:0] e;
    @(posedge clk); #1;
    reqValid = 1'b1;
    reqOp = op[3:0]; reqRs = rs[4:0]; reqRt = rt[4:0]; reqRd = rd[4:0]; reqImm = imm[15:0];
    acc = 1'b0;
    for (int i = 0; i < budget && !acc; i++) begin
      @(negedge clk);
      if (reqReady === 1'b1) acc = 1'b1;
      @(posedge clk); #1;
    end
    reqValid = 1'b0;
    if (acc) begin
      e = ref_enc(op, rs, rt, rd, imm);
      if (e[32]) m_err = 1'b1;
      else begin
        exp_addr.push_back(m_addr);
        exp_data.push_back(e[31:0]);
        m_addr++;
      end
    end
  endtask

  task automatic start_session();
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    m_addr = 0; m_err = 1'b0;
    exp_addr.delete(); exp_data.delete();
    base = obs_addr.size();
  endtask

  task automatic end_session(output bit ok);
    @(posedge clk); #1; finish = 1'b1;
    @(posedge clk); #1; finish = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (done === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (imemWe !== 1'b0) $display("FAIL rst_we: got %b want 0", imemWe); else n_pass++;
    n_checks++; if (imemAddr !== '0) $display("FAIL rst_addr: got %h want 0", imemAddr); else n_pass++;
    n_checks++; if (imemData !== 32'h0) $display("FAIL rst_data: got %h want 0", imemData); else n_pass++;
    n_checks++; if (loadCount !== '0) $display("FAIL rst_count: got %0d want 0", loadCount); else n_pass++;
    n_checks++; if (errIllegal !== 1'b0) $display("FAIL rst_err: got %b want 0", errIllegal); else n_pass++;
    n_checks++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL rst_state: busy %b done %b want 0 0", busy, done); else n_pass++;
    n_checks++; if (reqReady !== 1'b0) $display("FAIL rst_ready: got %b want 0", reqReady); else n_pass++;
    n_checks++; if (cpuHold !== 1'b1) $display("FAIL rst_hold: got %b want 1", cpuHold); else n_pass++;
    @(posedge clk); #1; rst_n = 1'b1;
  endtask

  task automatic test_basic();
    bit acc, ok;
    rdy_pct = 100;
    start_session();
    n_checks++; if (busy !== 1'b1 || cpuHold !== 1'b1) $display("FAIL basic_busy: busy %b hold %b want 1 1", busy, cpuHold); else n_pass++;
    send(0, 1, 2, 3, 0, 10, acc);
    send(4, 1, 2, 3, 0, 10, acc);
    end_session(ok);
    n_checks++; if (!ok) $display("FAIL basic_done: done never rose"); else n_pass++;
    n_checks++; if (obs_addr.size() - base !== 2) $display("FAIL basic_nwr: got %0d want 2", obs_addr.size() - base); else n_pass++;
    if (obs_addr.size() - base >= 2) begin
      n_checks++; if (obs_addr[base] !== 0 || obs_data[base] !== 32'h00221820) $display("FAIL basic_w0: got %0d/%h want 0/00221820", obs_addr[base], obs_data[base]); else n_pass++;
      n_checks++; if (obs_addr[base+1] !== 1 || obs_data[base+1] !== 32'h00221818) $display("FAIL basic_w1: got %0d/%h want 1/00221818", obs_addr[base+1], obs_data[base+1]); else n_pass++;
    end
    n_checks++; if (loadCount !== 4'd2) $display("FAIL basic_count: got %0d want 2", loadCount); else n_pass++;
    n_checks++; if (cpuHold !== 1'b0 || busy !== 1'b0) $display("FAIL basic_hold: hold %b busy %b want 0 0", cpuHold, busy); else n_pass++;
  endtask

  task automatic test_fields();
    bit acc, ok;
    logic [31:0] want[4];
    want = '{32'h24050010, 32'h8C860008, 32'hAC860008, 32'h2022FFFE};
    rdy_pct = 100;
    start_session();
    send(7, 0, 5, 31, 16'h0010, 10, acc);
    send(8, 4, 6, 31, 16'h0008, 10, acc);
    send(9, 4, 6, 31, 16'h0008, 10, acc);
    send(6, 1, 2, 31, 16'hFFFE, 10, acc);
    end_session(ok);
    n_checks++; if (!ok) $display("FAIL fields_done: done never rose"); else n_pass++;
    n_checks++; if (obs_addr.size() - base !== 4) $display("FAIL fields_nwr: got %0d want 4", obs_addr.size() - base); else n_pass++;
    for (int i = 0; i < 4 && base + i < obs_addr.size(); i++) begin
      n_checks++;
      if (obs_addr[base+i] !== i || obs_data[base+i] !== want[i])
        $display("FAIL fields_w%0d: got %0d/%h want %0d/%h", i, obs_addr[base+i], obs_data[base+i], i, want[i]);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    bit acc, ok;
    rdy_pct = 100;
    start_session();
    rdy_pct = 0;
    send(1, 7, 8, 9, 0, 10, acc);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++; if (imemWe !== 1'b1 || imemReady !== 1'b0) $display("FAIL bp_we%0d: we %b rdy %b want 1 0", c, imemWe, imemReady); else n_pass++;
      n_checks++; if (imemAddr !== '0 || imemData !== exp_data[0]) $display("FAIL bp_hold%0d: got %0d/%h want 0/%h", c, imemAddr, imemData, exp_data[0]); else n_pass++;
      n_checks++; if (reqReady !== 1'b0) $display("FAIL bp_ready%0d: got %b want 0", c, reqReady); else n_pass++;
    end
    rdy_pct = 100;
    @(negedge clk);
    n_checks++; if (imemWe !== 1'b1 || imemReady !== 1'b1) $display("FAIL bp_fire: we %b rdy %b want 1 1", imemWe, imemReady); else n_pass++;
    n_checks++; if (reqReady !== 1'b1) $display("FAIL bp_ready_back: got %b want 1", reqReady); else n_pass++;
    end_session(ok);
    n_checks++; if (!ok) $display("FAIL bp_done: done never rose"); else n_pass++;
    n_checks++; if (obs_addr.size() - base !== 1) $display("FAIL bp_nwr: got %0d want 1", obs_addr.size() - base); else n_pass++;
  endtask

  task automatic test_illegal();
    bit acc, ok;
    rdy_pct = 100;
    start_session();
    send(0, 1, 1, 1, 0, 10, acc);
    send(12, 3, 3, 3, 5, 10, acc);
    n_checks++; if (!acc) $display("FAIL ill_acc: illegal request not accepted"); else n_pass++;
    @(negedge clk);
    n_checks++; if (errIllegal !== 1'b1) $display("FAIL ill_flag: got %b want 1", errIllegal); else n_pass++;
    send(7, 2, 3, 0, 16'h1234, 10, acc);
    end_session(ok);
    n_checks++; if (obs_addr.size() - base !== 2) $display("FAIL ill_nwr: got %0d want 2", obs_addr.size() - base); else n_pass++;
    if (obs_addr.size() - base >= 2) begin
      n_checks++; if (obs_addr[base+1] !== 1 || obs_data[base+1] !== 32'h24431234) $display("FAIL ill_next: got %0d/%h want 1/24431234", obs_addr[base+1], obs_data[base+1]); else n_pass++;
    end
    n_checks++; if (loadCount !== 4'd2 || errIllegal !== 1'b1) $display("FAIL ill_end: count %0d err %b want 2 1", loadCount, errIllegal); else n_pass++;
    start_session();
    @(negedge clk);
    n_checks++; if (errIllegal !== 1'b0) $display("FAIL ill_clear: got %b want 0", errIllegal); else n_pass++;
    end_session(ok);
  endtask

  task automatic test_random();
    bit acc, ok;
    for (int s = 0; s < 3; s++) begin
      rdy_pct = 60;
      start_session();
      for (int r = 0; r < 6; r++) begin
        send($urandom_range(0, 11), $urandom_range(0, 31), $urandom_range(0, 31),
             $urandom_range(0, 31), $urandom_range(0, 65535), 50, acc);
        n_checks++; if (!acc) $display("FAIL rnd_acc s%0d r%0d: request not accepted", s, r); else n_pass++;
      end
      end_session(ok);
      n_checks++; if (!ok) $display("FAIL rnd_done s%0d: done never rose", s); else n_pass++;
      n_checks++; if (obs_addr.size() - base !== exp_addr.size()) $display("FAIL rnd_nwr s%0d: got %0d want %0d", s, obs_addr.size() - base, exp_addr.size()); else n_pass++;
      for (int i = 0; i < exp_addr.size() && base + i < obs_addr.size(); i++) begin
        n_checks++;
        if (obs_addr[base+i] !== exp_addr[i] || obs_data[base+i] !== exp_data[i])
          $display("FAIL rnd_w s%0d i%0d: got %0d/%h want %0d/%h", s, i, obs_addr[base+i], obs_data[base+i], exp_addr[i], exp_data[i]);
        else n_pass++;
      end
      n_checks++; if (int'(loadCount) !== m_addr || errIllegal !== m_err) $display("FAIL rnd_cnt s%0d: count %0d err %b want %0d %b", s, loadCount, errIllegal, m_addr, m_err); else n_pass++;
    end
  endtask

  task automatic test_full();
    bit acc;
    rdy_pct = 100;
    start_session();
    for (int r = 0; r < DEPTH + 2; r++) begin
      send($urandom_range(0, 9), r, r + 1, r + 2, r * 3, 8, acc);
      n_checks++; if (acc !== (r < DEPTH)) $display("FAIL full_acc r%0d: got %b want %b", r, acc, r < DEPTH); else n_pass++;
    end
    @(negedge clk);
    n_checks++; if (done !== 1'b1 || cpuHold !== 1'b0) $display("FAIL full_done: done %b hold %b want 1 0", done, cpuHold); else n_pass++;
    n_checks++; if (obs_addr.size() - base !== DEPTH) $display("FAIL full_nwr: got %0d want %0d", obs_addr.size() - base, DEPTH); else n_pass++;
    for (int i = 0; i < DEPTH && base + i < obs_addr.size(); i++) begin
      n_checks++;
      if (obs_addr[base+i] !== i || obs_data[base+i] !== exp_data[i])
        $display("FAIL full_w%0d: got %0d/%h want %0d/%h", i, obs_addr[base+i], obs_data[base+i], i, exp_data[i]);
      else n_pass++;
    end
    n_checks++; if (int'(loadCount) !== DEPTH) $display("FAIL full_count: got %0d want %0d", loadCount, DEPTH); else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit acc, ok;
    rdy_pct = 100;
    start_session();
    rdy_pct = 0;
    send(2, 5, 6, 7, 0, 10, acc);
    @(posedge clk); #1; rst_n = 1'b0;
    @(negedge clk);
    n_checks++; if (imemWe !== 1'b0 || cpuHold !== 1'b1) $display("FAIL mid_rst: we %b hold %b want 0 1", imemWe, cpuHold); else n_pass++;
    n_checks++; if (busy !== 1'b0 || done !== 1'b0 || reqReady !== 1'b0) $display("FAIL mid_idle: busy %b done %b rdy %b want 0 0 0", busy, done, reqReady); else n_pass++;
    n_checks++; if (loadCount !== '0 || imemData !== 32'h0) $display("FAIL mid_clr: count %0d data %h want 0 0", loadCount, imemData); else n_pass++;
    @(posedge clk); #1; rst_n = 1'b1;
    rdy_pct = 100;
    start_session();
    send(1, 9, 10, 11, 0, 10, acc);
    end_session(ok);
    n_checks++; if (obs_addr.size() - base !== 1) $display("FAIL mid_nwr: got %0d want 1", obs_addr.size() - base); else n_pass++;
    if (obs_addr.size() - base >= 1) begin
      n_checks++; if (obs_addr[base] !== 0 || obs_data[base] !== 32'h012A5822) $display("FAIL mid_w0: got %0d/%h want 0/012a5822", obs_addr[base], obs_data[base]); else n_pass++;
    end
  endtask

`ifdef ENC_PAD_EN
  task automatic test_pad();
    bit acc, ok;
    rdy_pct = 70;
    start_session();
    send(3, 1, 2, 3, 0, 50, acc);
    send(5, 4, 5, 0, 16'h0003, 50, acc);
    end_session(ok);
    n_checks++; if (!ok) $display("FAIL pad_done: done never rose"); else n_pass++;
    n_checks++; if (obs_addr.size() - base !== DEPTH) $display("FAIL pad_nwr: got %0d want %0d", obs_addr.size() - base, DEPTH); else n_pass++;
    for (int i = 0; i < DEPTH && base + i < obs_addr.size(); i++) begin
      n_checks++;
      if (obs_addr[base+i] !== i || obs_data[base+i] !== ((i < 2) ? exp_data[i] : 32'h0))
        $display("FAIL pad_w%0d: got %0d/%h", i, obs_addr[base+i], obs_data[base+i]);
      else n_pass++;
    end
    n_checks++; if (loadCount !== 4'd2) $display("FAIL pad_count: got %0d want 2", loadCount); else n_pass++;
  endtask
`endif

  initial begin
    rst_n = 1'b0; start = 1'b0; finish = 1'b0; reqValid = 1'b0;
    reqOp = '0; reqRs = '0; reqRt = '0; reqRd = '0; reqImm = '0;
    test_reset();
    test_basic();
    test_fields();
    test_backpressure();
    test_illegal();
    test_random();
    test_full();
    test_reset_mid();
`ifdef ENC_PAD_EN
    test_pad();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
